// File: rtl/jtframe_bank_arb.sv
// Round-robin SDRAM bank arbiter: CH game channels share one controller port,
// with a download bypass that hands the port to the ROM loader.
module jtframe_bank_arb #(
  parameter int            CH    = 4,
  parameter int            AW    = 22,
  parameter int            DW    = 16,
  parameter logic [CH-1:0] WREN  = CH'(1),
  parameter logic          PRIO0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH*AW-1:0] ch_addr,
  input  logic [CH-1:0]    ch_rd,
  input  logic [CH-1:0]    ch_wr,
  input  logic [CH*DW-1:0] ch_din,
  input  logic [CH*2-1:0]  ch_din_m,
  output logic [CH-1:0]    ch_ack,
  output logic [CH-1:0]    ch_rdy,
  output logic [DW-1:0]    ch_dout,
  input  logic             prog_en,
  input  logic [AW-1:0]    prog_addr,
  input  logic             prog_rd,
  input  logic             prog_we,
  input  logic [DW-1:0]    prog_data,
  input  logic [1:0]       prog_mask,
  output logic             prog_ack,
  output logic             prog_rdy,
  output logic [AW-1:0]    sdr_addr,
  output logic             sdr_rd,
  output logic             sdr_wr,
  output logic [DW-1:0]    sdr_din,
  output logic [1:0]       sdr_din_m,
  input  logic             sdr_ack,
  input  logic             sdr_rdy,
  input  logic [DW-1:0]    sdr_dout
);

  localparam int GW = $clog2(CH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_PROG} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [1:0]    mask_q, mask_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [CH-1:0] rdy_q, rdy_d;

  logic [CH-1:0] req;
  logic [GW-1:0] win;
  logic [GW:0]   cand;
  logic          found;
  logic          win_wr;

  assign req = ch_rd | (ch_wr & WREN);

  // Scan from the pointer upward with wrap; channel 0 may override the scan.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < CH; k++) begin
      cand = {1'b0, ptr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(CH)) cand = cand - (GW+1)'(CH);
      if (!found && req[cand[GW-1:0]]) begin
        found = 1'b1;
        win   = cand[GW-1:0];
      end
    end
    if (PRIO0 && req[0]) begin
      found = 1'b1;
      win   = '0;
    end
  end

  assign win_wr = ch_wr[win] & WREN[win];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    mask_d  = mask_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    rdy_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (prog_en) begin
          state_d = S_PROG;
        end else if (found) begin
          grant_d = win;
          ptr_d   = (win == GW'(CH-1)) ? '0 : win + GW'(1);
          addr_d  = ch_addr[int'(win)*AW +: AW];
          din_d   = ch_din[int'(win)*DW +: DW];
          mask_d  = ch_din_m[int'(win)*2 +: 2];
          wr_d    = win_wr;
          rd_d    = ~win_wr;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (sdr_ack) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (sdr_rdy) begin
            dout_d         = sdr_dout;
            rdy_d[grant_q] = 1'b1;
            state_d        = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (sdr_rdy) begin
          dout_d         = sdr_dout;
          rdy_d[grant_q] = 1'b1;
          state_d        = S_IDLE;
        end
      end
      S_PROG: begin
        if (!prog_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      mask_q  <= 2'b11;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
    end
  end

  // Acknowledge is passed straight through so the channel sees it with sdr_ack.
  always_comb begin
    ch_ack = '0;
    if (state_q == S_REQ && sdr_ack) ch_ack[grant_q] = 1'b1;
  end

  assign ch_rdy    = rdy_q;
  assign ch_dout   = dout_q;
  assign prog_ack  = (state_q == S_PROG) & sdr_ack;
  assign prog_rdy  = (state_q == S_PROG) & sdr_rdy;
  assign sdr_addr  = (state_q == S_PROG) ? prog_addr : addr_q;
  assign sdr_rd    = (state_q == S_PROG) ? prog_rd   : rd_q;
  assign sdr_wr    = (state_q == S_PROG) ? prog_we   : wr_q;
  assign sdr_din   = (state_q == S_PROG) ? prog_data : din_q;
  assign sdr_din_m = (state_q == S_PROG) ? prog_mask : mask_q;

endmodule

// File: tb/tb_jtframe_bank_arb.sv
// Bench for jtframe_bank_arb: a simple SDRAM controller model answers each
// request; completions are checked against a queue of expected results.
`timescale 1ns/1ps
module tb_jtframe_bank_arb;

  localparam int CH = 4;
  localparam int AW = 22;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [CH*AW-1:0] ch_addr;
  logic [CH-1:0]    ch_rd, ch_wr, p_ch_rd;
  logic [CH*DW-1:0] ch_din;
  logic [CH*2-1:0]  ch_din_m;
  logic [CH-1:0]    ch_ack, ch_rdy, p_ch_ack, p_ch_rdy;
  logic [DW-1:0]    ch_dout, p_ch_dout;
  logic             prog_en, prog_rd, prog_we;
  logic [AW-1:0]    prog_addr;
  logic [DW-1:0]    prog_data;
  logic [1:0]       prog_mask;
  logic             prog_ack, prog_rdy, p_prog_ack, p_prog_rdy;

  logic [AW-1:0] s_addr [2];
  logic          s_rd   [2];
  logic          s_wr   [2];
  logic [DW-1:0] s_din  [2];
  logic [1:0]    s_dm   [2];
  logic          s_ack  [2];
  logic          s_rdy  [2];
  logic [DW-1:0] s_dout [2];
  bit            slave_en;

  jtframe_bank_arb #(.CH(CH), .AW(AW), .DW(DW), .WREN(4'b0001), .PRIO0(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_din(ch_din), .ch_din_m(ch_din_m),
    .ch_ack(ch_ack), .ch_rdy(ch_rdy), .ch_dout(ch_dout),
    .prog_en(prog_en), .prog_addr(prog_addr), .prog_rd(prog_rd), .prog_we(prog_we),
    .prog_data(prog_data), .prog_mask(prog_mask), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
    .sdr_addr(s_addr[0]), .sdr_rd(s_rd[0]), .sdr_wr(s_wr[0]), .sdr_din(s_din[0]),
    .sdr_din_m(s_dm[0]), .sdr_ack(s_ack[0]), .sdr_rdy(s_rdy[0]), .sdr_dout(s_dout[0])
  );

  jtframe_bank_arb #(.CH(CH), .AW(AW), .DW(DW), .WREN(4'b0001), .PRIO0(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .ch_addr(ch_addr), .ch_rd(p_ch_rd), .ch_wr(4'b0000), .ch_din(ch_din), .ch_din_m(ch_din_m),
    .ch_ack(p_ch_ack), .ch_rdy(p_ch_rdy), .ch_dout(p_ch_dout),
    .prog_en(1'b0), .prog_addr(22'h0), .prog_rd(1'b0), .prog_we(1'b0),
    .prog_data(16'h0), .prog_mask(2'b11), .prog_ack(p_prog_ack), .prog_rdy(p_prog_rdy),
    .sdr_addr(s_addr[1]), .sdr_rd(s_rd[1]), .sdr_wr(s_wr[1]), .sdr_din(s_din[1]),
    .sdr_din_m(s_dm[1]), .sdr_ack(s_ack[1]), .sdr_rdy(s_rdy[1]), .sdr_dout(s_dout[1])
  );

  typedef struct { int ch; logic [15:0] dat; } exp_t;
  exp_t sb [$];
  int   n_tests, n_fail;

  function automatic logic [15:0] resp(input logic [15:0] a);
    return a ^ 16'hACDB;
  endfunction

  function automatic logic [AW-1:0] caddr(input int i);
    return AW'(32'h1034 + 32'h100 * i);
  endfunction

  // Controller model: ack one cycle after a request, rdy two cycles after ack.
  int          sl_st  [2];
  logic [15:0] sl_dat [2];
  initial begin
    for (int u = 0; u < 2; u++) begin
      s_ack[u] = 1'b0; s_rdy[u] = 1'b0; s_dout[u] = '0; sl_st[u] = 0; sl_dat[u] = '0;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        s_ack[u] = 1'b0;
        s_rdy[u] = 1'b0;
        if (!slave_en || !rst_n) begin
          sl_st[u] = 0;
        end else begin
          case (sl_st[u])
            0: if (s_rd[u] || s_wr[u]) begin
                 s_ack[u]  = 1'b1;
                 sl_dat[u] = resp(s_addr[u][15:0]);
                 sl_st[u]  = 1;
               end
            1: sl_st[u] = 2;
            default: begin
              s_rdy[u]  = 1'b1;
              s_dout[u] = sl_dat[u];
              sl_st[u]  = 0;
            end
          endcase
        end
      end
    end
  end

  task automatic wait_rdy(input int u, output logic [3:0] rdy, output logic [15:0] dout,
                          output bit tmo);
    tmo = 1'b1; rdy = '0; dout = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      rdy  = (u == 0) ? ch_rdy  : p_ch_rdy;
      dout = (u == 0) ? ch_dout : p_ch_dout;
      if (rdy != 0) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_tests++;
    if (s_rd[0] !== 1'b0 || s_wr[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdwr: rd=%b wr=%b, want 0 0", s_rd[0], s_wr[0]);
    end
    n_tests++;
    if (ch_ack !== 4'b0 || ch_rdy !== 4'b0 || prog_ack !== 1'b0 || prog_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: ack=%b rdy=%b pack=%b prdy=%b, want all 0",
                         ch_ack, ch_rdy, prog_ack, prog_rdy);
    end
    n_tests++;
    if (ch_dout !== 16'h0 || s_addr[0] !== 22'h0 || s_din[0] !== 16'h0) begin
      n_fail++; $display("FAIL reset_data: dout=%h addr=%h din=%h, want 0", ch_dout, s_addr[0], s_din[0]);
    end
    n_tests++;
    if (s_dm[0] !== 2'b11) begin
      n_fail++; $display("FAIL reset_mask: got %b want 11", s_dm[0]);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_single_read();
    logic [3:0] rdy; logic [15:0] dout; bit tmo; exp_t e;
    sb.delete();
    ch_rd = 4'b0100;
    sb.push_back('{2, 16'hBEEF});
    @(negedge clk); #1;
    n_tests++;
    if (s_rd[0] !== 1'b1 || s_wr[0] !== 1'b0 || s_addr[0] !== 22'h1234) begin
      n_fail++; $display("FAIL single_req: rd=%b wr=%b addr=%h, want 1 0 001234", s_rd[0], s_wr[0], s_addr[0]);
    end
    n_tests++;
    if (ch_ack !== 4'b0100 || prog_ack !== 1'b0) begin
      n_fail++; $display("FAIL single_ack: ack=%b pack=%b, want 0100 0", ch_ack, prog_ack);
    end
    ch_rd = 4'b0000;
    wait_rdy(0, rdy, dout, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || rdy !== (4'b0001 << e.ch) || dout !== e.dat) begin
      n_fail++; $display("FAIL single_rdy: rdy=%b dout=%h tmo=%0d, want rdy=%b dout=%h",
                         rdy, dout, tmo, 4'b0001 << e.ch, e.dat);
    end
    @(negedge clk); #1;
    n_tests++;
    if (ch_rdy !== 4'b0) begin
      n_fail++; $display("FAIL single_rdy_pulse: rdy=%b, want 0000", ch_rdy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rdy; logic [15:0] dout; bit tmo; exp_t e;
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    sb.delete();
    foreach (order[i]) sb.push_back('{order[i], resp(caddr(order[i])[15:0])});
    ch_rd = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_rdy(0, rdy, dout, tmo);
      if (t == 4) ch_rd = 4'b0000;
      e = sb.pop_front();
      n_tests++;
      if (tmo || rdy !== (4'b0001 << e.ch) || dout !== e.dat) begin
        n_fail++; $display("FAIL rr_%0d: rdy=%b dout=%h tmo=%0d, want rdy=%b dout=%h",
                           t, rdy, dout, tmo, 4'b0001 << e.ch, e.dat);
      end
    end
  endtask

  task automatic test_prio0();
    logic [3:0] rdy; logic [15:0] dout; bit tmo; exp_t e;
    int order [4] = '{0, 0, 0, 3};
    sb.delete();
    foreach (order[i]) sb.push_back('{order[i], resp(caddr(order[i])[15:0])});
    p_ch_rd = 4'b1001;
    for (int t = 0; t < 4; t++) begin
      wait_rdy(1, rdy, dout, tmo);
      if (t == 2) p_ch_rd = 4'b1000;
      if (t == 3) p_ch_rd = 4'b0000;
      e = sb.pop_front();
      n_tests++;
      if (tmo || rdy !== (4'b0001 << e.ch) || dout !== e.dat) begin
        n_fail++; $display("FAIL prio_%0d: rdy=%b dout=%h tmo=%0d, want rdy=%b dout=%h",
                           t, rdy, dout, tmo, 4'b0001 << e.ch, e.dat);
      end
    end
  endtask

  task automatic test_write();
    logic [3:0] rdy; logic [15:0] dout; bit tmo; exp_t e;
    int bad = 0;
    sb.delete();
    ch_wr = 4'b0010;
    repeat (8) begin
      @(negedge clk); #1;
      if (s_wr[0] || s_rd[0] || ch_ack != 4'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL wr_blocked: %0d active cycles, want 0", bad);
    end
    ch_wr = 4'b0000;
    ch_din[15:0]  = 16'hCAFE;
    ch_din_m[1:0] = 2'b10;
    ch_wr = 4'b0001;
    sb.push_back('{0, resp(caddr(0)[15:0])});
    @(negedge clk); #1;
    n_tests++;
    if (s_wr[0] !== 1'b1 || s_rd[0] !== 1'b0 || s_dm[0] !== 2'b10 || s_din[0] !== 16'hCAFE) begin
      n_fail++; $display("FAIL wr_req: wr=%b rd=%b mask=%b din=%h, want 1 0 10 cafe",
                         s_wr[0], s_rd[0], s_dm[0], s_din[0]);
    end
    n_tests++;
    if (ch_ack !== 4'b0001) begin
      n_fail++; $display("FAIL wr_ack: ack=%b, want 0001", ch_ack);
    end
    ch_wr = 4'b0000;
    ch_din_m = '1;
    wait_rdy(0, rdy, dout, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || rdy !== (4'b0001 << e.ch) || dout !== e.dat) begin
      n_fail++; $display("FAIL wr_rdy: rdy=%b dout=%h tmo=%0d, want rdy=%b dout=%h",
                         rdy, dout, tmo, 4'b0001 << e.ch, e.dat);
    end
    ch_rd = 4'b0001;
    ch_wr = 4'b0001;
    sb.push_back('{0, resp(caddr(0)[15:0])});
    @(negedge clk); #1;
    n_tests++;
    if (s_wr[0] !== 1'b1 || s_rd[0] !== 1'b0) begin
      n_fail++; $display("FAIL rdwr_prio: wr=%b rd=%b, want 1 0", s_wr[0], s_rd[0]);
    end
    ch_rd = 4'b0000;
    ch_wr = 4'b0000;
    wait_rdy(0, rdy, dout, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || rdy !== (4'b0001 << e.ch)) begin
      n_fail++; $display("FAIL rdwr_rdy: rdy=%b tmo=%0d, want rdy=%b", rdy, tmo, 4'b0001 << e.ch);
    end
  endtask

  task automatic test_prog();
    logic [3:0] rdy; logic [15:0] dout; bit tmo; exp_t e;
    bit got;
    sb.delete();
    ch_rd = 4'b0010;
    sb.push_back('{1, resp(caddr(1)[15:0])});
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (ch_ack[1]) begin got = 1'b1; break; end
    end
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL prog_ch1_ack: no ack seen, want ack[1]");
    end
    ch_rd   = 4'b0000;
    prog_en = 1'b1;
    wait_rdy(0, rdy, dout, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || rdy !== (4'b0001 << e.ch) || dout !== e.dat) begin
      n_fail++; $display("FAIL prog_ch1_rdy: rdy=%b dout=%h tmo=%0d, want rdy=%b dout=%h",
                         rdy, dout, tmo, 4'b0001 << e.ch, e.dat);
    end
    prog_addr = 22'h3C0DE;
    ch_rd     = 4'b0101;
    @(negedge clk); #1;
    n_tests++;
    if (s_addr[0] !== 22'h3C0DE || s_rd[0] !== 1'b0) begin
      n_fail++; $display("FAIL prog_addr: addr=%h rd=%b, want 3c0de 0", s_addr[0], s_rd[0]);
    end
    prog_rd = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (prog_ack !== 1'b1 || ch_ack !== 4'b0) begin
      n_fail++; $display("FAIL prog_ack: pack=%b ack=%b, want 1 0000", prog_ack, ch_ack);
    end
    prog_rd = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (prog_rdy) begin got = 1'b1; break; end
    end
    n_tests++;
    if (!got || ch_rdy !== 4'b0) begin
      n_fail++; $display("FAIL prog_rdy: seen=%0d ch_rdy=%b, want 1 0000", got, ch_rdy);
    end
    sb.push_back('{2, resp(caddr(2)[15:0])});
    sb.push_back('{0, resp(caddr(0)[15:0])});
    prog_en = 1'b0;
    for (int t = 0; t < 2; t++) begin
      wait_rdy(0, rdy, dout, tmo);
      if (t == 1) ch_rd = 4'b0000;
      e = sb.pop_front();
      n_tests++;
      if (tmo || rdy !== (4'b0001 << e.ch) || dout !== e.dat) begin
        n_fail++; $display("FAIL prog_resume_%0d: rdy=%b dout=%h tmo=%0d, want rdy=%b dout=%h",
                           t, rdy, dout, tmo, 4'b0001 << e.ch, e.dat);
      end
    end
    n_tests++;
    if (prog_ack !== 1'b0 || prog_rdy !== 1'b0) begin
      n_fail++; $display("FAIL prog_idle: pack=%b prdy=%b, want 0 0", prog_ack, prog_rdy);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    slave_en = 1'b0;
    @(negedge clk); #1;
    ch_rd = 4'b1000;
    @(negedge clk); #1;
    n_tests++;
    if (s_rd[0] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_req: rd=%b, want 1", s_rd[0]);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (s_rd[0] !== 1'b0 || ch_ack !== 4'b0 || s_addr[0] !== 22'h0 || s_dm[0] !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_async: rd=%b ack=%b addr=%h mask=%b, want 0 0000 0 11",
                         s_rd[0], ch_ack, s_addr[0], s_dm[0]);
    end
    ch_rd = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    slave_en = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      if (ch_rdy != 4'b0 || s_rd[0]) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL rstmid_norsp: %0d cycles with rdy/rd, want 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    slave_en  = 1'b1;
    ch_rd     = '0;
    ch_wr     = '0;
    p_ch_rd   = '0;
    ch_din    = '0;
    ch_din_m  = '1;
    prog_en   = 1'b0;
    prog_rd   = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = 16'h5555;
    prog_mask = 2'b11;
    for (int i = 0; i < CH; i++) ch_addr[i*AW +: AW] = caddr(i);

    test_reset();
    test_single_read();
    test_round_robin();
    test_prio0();
    test_write();
    test_prog();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_bank_arb.md
Name: jtframe_bank_arb

Overview:
- Parametrised N-channel SDRAM bank arbiter.
- Successor to the fixed four-bank `ba0..ba3` wiring at the MiST/MiSTer top level: any number of game-side channels share one SDRAM controller request port.
- Round-robin arbitration, with an optional fixed-priority channel 0 and per-channel write permission.
- A download bypass hands the port to the ROM-load (`prog_*`) interface.

Parameters:
- CH, 4: number of game channels (2..8).
- AW, 22: address width.
- DW, 16: data width.
- WREN, 4'b0001: bitmask of channels allowed to write; `wr` is ignored on other channels.
- PRIO0, 0: when 1, channel 0 wins over any other pending channel.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_addr  in  CH*AW  channel addresses, channel i at [i*AW +: AW].
- ch_rd  in  CH  read requests (level).
- ch_wr  in  CH  write requests (level).
- ch_din  in  CH*DW  write data.
- ch_din_m  in  CH*2  write byte mask, active-low per byte.
- ch_ack  out  CH  request accepted.
- ch_rdy  out  CH  transaction complete; read data valid.
- ch_dout  out  DW  shared read data, registered.
- prog_en  in  1  download in progress.
- prog_addr  in  AW  download address.
- prog_rd  in  1  download read request.
- prog_we  in  1  download write request.
- prog_data  in  DW  download write data.
- prog_mask  in  2  download byte mask.
- prog_ack  out  1  download accepted.
- prog_rdy  out  1  download complete.
- sdr_addr  out  AW  controller address.
- sdr_rd  out  1  controller read request.
- sdr_wr  out  1  controller write request.
- sdr_din  out  DW  controller write data.
- sdr_din_m  out  2  controller byte mask.
- sdr_ack  in  1  controller accepted request.
- sdr_rdy  in  1  controller finished; `sdr_dout` valid.
- sdr_dout  in  DW  controller read data.

Behaviour:
- Reset (async, `rst_n`=0):
  - state IDLE, grant cleared, round-robin pointer = 0.
  - `sdr_rd`, `sdr_wr`, `ch_ack`, `ch_rdy`, `prog_ack`, `prog_rdy` = 0.
  - `ch_dout`, `sdr_addr`, `sdr_din` = 0; `sdr_din_m` = 2'b11.
  - Reset mid-transaction drops the request; no `ch_rdy` is produced.
- Effective request for channel i: `req[i] = ch_rd[i] | (ch_wr[i] & WREN[i])`.
- FSM states: IDLE, REQ, WAIT, PROG.
- IDLE:
  - If `prog_en`=1 -> PROG.
  - Else, if any `req` is set, pick a winner:
    - PRIO0=1 and `req[0]`=1: channel 0 wins.
    - Otherwise the first requester scanning from pointer upward, wrapping at CH-1 -> 0.
  - Latch grant, address, data and mask into `sdr_*` registers.
  - `sdr_wr` = `ch_wr[g] & WREN[g]`; `sdr_rd` = `!sdr_wr`. Write wins when rd and wr are both set.
  - Go to REQ. Pointer = g+1 mod CH; channel 0 granted through PRIO0 also advances the pointer.
  - Latency: request at cycle n -> `sdr_rd`/`sdr_wr` high at n+1.
- REQ:
  - Hold `sdr_rd`/`sdr_wr` until `sdr_ack`.
  - On `sdr_ack`: `ch_ack[g]` = 1 the same cycle (combinational pass-through), drop `sdr_rd`/`sdr_wr` next cycle.
  - -> WAIT, or -> IDLE if `sdr_rdy` is also high that cycle.
- WAIT: on `sdr_rdy`, register `ch_dout` <= `sdr_dout`, pulse `ch_rdy[g]` for one cycle at n+1, -> IDLE.
- Back-to-back transactions: a new grant may be issued in the IDLE cycle following `sdr_rdy`.
- Channel dropping its request after grant: the transaction still completes; `ch_ack`/`ch_rdy` still pulse.
- Write on a non-WREN channel with `rd`=0: never requested; no ack.
- `prog_en` rising during REQ/WAIT: the current transaction finishes normally, then -> PROG.
- PROG:
  - `sdr_*` driven combinationally from `prog_*`.
  - `prog_ack` = `sdr_ack`; `prog_rdy` = `sdr_rdy`.
  - All `ch_ack`/`ch_rdy` = 0; channel requests are ignored.
  - `prog_en` falling -> IDLE next cycle; pointer is preserved.
- Outside PROG, `prog_ack` = `prog_rdy` = 0.
- At most one bit of `ch_ack` and one bit of `ch_rdy` is set in any cycle.

Test Plan:
- Reset release with CH=4, `ch_rd`=4'b0100 at addr 0x1234 -> `sdr_rd`=1, `sdr_addr`=0x1234 one cycle later. After `sdr_ack` then `sdr_rdy` with `sdr_dout`=0xBEEF: `ch_ack[2]` pulses, then `ch_rdy[2]` pulses with `ch_dout`=0xBEEF.
- All four channels holding `rd` continuously, PRIO0=0 -> grant order 0,1,2,3,0 with no channel repeated before the others are served.
- PRIO0=1, channels 0 and 3 requesting repeatedly -> channel 0 is granted every time; channel 3 only in cycles where `req[0]`=0.
- `ch_wr[1]`=1 with WREN=4'b0001 -> no `sdr_wr`, no `ch_ack[1]`. `ch_wr[0]`=1 with `din_m`=2'b10 -> `sdr_wr`=1, `sdr_din_m`=2'b10.
- `prog_en` asserted while channel 1 is in WAIT -> `ch_rdy[1]` still pulses, then `sdr_addr` follows `prog_addr` and `prog_ack` mirrors `sdr_ack`. `prog_en` low -> arbitration resumes.
- `rst_n` pulsed low during REQ -> all outputs 0 immediately; no `ch_rdy` afterwards for the aborted request.
